// File: rtl/fht_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fht_seq_ctrl
//   Sequencing controller for an in-place fast Hartley transform engine.
//   A frame runs through four phases:
//     IDLE   -> waits for i_start
//     LOAD   -> accepts NPT serial samples into the input buffer
//     RUN    -> fires the butterfly stage NPASS times, pass 0 from the input
//               buffer, later passes from the stage-output feedback path
//     UNLOAD -> presents NPT result indices to the downstream consumer
//   The controller never touches sample data; word growth across passes is
//   handled by the datapath.
//
// Ports
//   i_clk         clock, rising-edge active
//   i_rst         asynchronous active-high reset
//   i_start       frame request (sampled only in IDLE)
//   i_abort       synchronous abort, returns to IDLE from any state
//   i_din_valid   serial input sample present
//   o_din_ready   controller accepts an input sample (LOAD)
//   o_wr_en       input-buffer write strobe
//   o_wr_addr     input-buffer write address
//   o_fht_star    butterfly-stage enable, one pass per asserted cycle
//   o_fb_sel      stage source: 0 = input buffer, 1 = stage feedback
//   o_pass        index of the pass being executed
//   o_dout_valid  result sample at o_rd_addr is valid (UNLOAD)
//   i_dout_ready  downstream accepts a result sample
//   o_rd_addr     result read index
//   o_busy        high in every state except IDLE
//   o_done        one-cycle pulse on frame completion
// -----------------------------------------------------------------------------
module fht_seq_ctrl #(
    parameter int NPT   = 16,
    parameter int NPASS = 4,
    parameter int AW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_din_valid,
    output logic          o_din_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_fht_star,
    output logic          o_fb_sel,
    output logic [1:0]    o_pass,
    output logic          o_dout_valid,
    input  logic          i_dout_ready,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        UNLOAD = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NPT - 1);
    localparam logic [1:0]    LAST_PASS = 2'(NPASS - 1);

    state_t        r_state;
    logic          r_din_ready;
    logic          r_fht_star;
    logic          r_fb_sel;
    logic          r_dout_valid;
    logic          r_busy;
    logic          r_done;
    logic [AW-1:0] r_wr_addr;
    logic [AW-1:0] r_rd_addr;
    logic [1:0]    r_pass;

    logic          w_wr_en;
    logic          w_rd_acc;

    // Write strobe is combinational so a sample is taken in the same cycle
    // it is offered; r_din_ready is only high in LOAD, which also makes
    // i_din_valid irrelevant in every other state.
    assign w_wr_en  = i_din_valid & r_din_ready;
    assign w_rd_acc = r_dout_valid & i_dout_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_din_ready  <= 1'b0;
            r_fht_star   <= 1'b0;
            r_fb_sel     <= 1'b0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_pass       <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                // Abort outranks every other input, including Start in IDLE.
                r_state      <= IDLE;
                r_din_ready  <= 1'b0;
                r_fht_star   <= 1'b0;
                r_fb_sel     <= 1'b0;
                r_dout_valid <= 1'b0;
                r_busy       <= 1'b0;
                r_wr_addr    <= '0;
                r_rd_addr    <= '0;
                r_pass       <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_start) begin
                            r_state     <= LOAD;
                            r_din_ready <= 1'b1;
                            r_busy      <= 1'b1;
                            r_wr_addr   <= '0;
                            r_rd_addr   <= '0;
                        end
                    end
                    LOAD: begin
                        if (w_wr_en) begin
                            if (r_wr_addr == LAST_ADDR) begin
                                r_state     <= RUN;
                                r_din_ready <= 1'b0;
                                r_wr_addr   <= '0;
                                r_fht_star  <= 1'b1;
                                r_fb_sel    <= 1'b0;
                                r_pass      <= '0;
                            end else begin
                                r_wr_addr <= r_wr_addr + AW'(1);
                            end
                        end
                    end
                    RUN: begin
                        // The stage has one cycle of latency, so UNLOAD starts
                        // the cycle after the final pass.
                        if (r_pass == LAST_PASS) begin
                            r_state      <= UNLOAD;
                            r_fht_star   <= 1'b0;
                            r_fb_sel     <= 1'b0;
                            r_pass       <= '0;
                            r_dout_valid <= 1'b1;
                        end else begin
                            r_pass   <= r_pass + 2'd1;
                            r_fb_sel <= 1'b1;
                        end
                    end
                    UNLOAD: begin
                        if (w_rd_acc) begin
                            if (r_rd_addr == LAST_ADDR) begin
                                r_state      <= IDLE;
                                r_dout_valid <= 1'b0;
                                r_busy       <= 1'b0;
                                r_rd_addr    <= '0;
                                r_done       <= 1'b1;
                            end else begin
                                r_rd_addr <= r_rd_addr + AW'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_din_ready  = r_din_ready;
    assign o_wr_en      = w_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_fht_star   = r_fht_star;
    assign o_fb_sel     = r_fb_sel;
    assign o_pass       = r_pass;
    assign o_dout_valid = r_dout_valid;
    assign o_rd_addr    = r_rd_addr;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule

// File: tb/tb_fht_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fht_seq_ctrl
//   Directed bench for fht_seq_ctrl. Expected write addresses, pass/feedback
//   pairs and read addresses are queued when a frame is requested and popped
//   as the controller emits the matching strobes.
// -----------------------------------------------------------------------------
module tb_fht_seq_ctrl;

    localparam int NPT   = 16;
    localparam int NPASS = 4;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          din_valid;
    logic          dout_ready;
    logic          o_din_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic          o_fht_star;
    logic          o_fb_sel;
    logic [1:0]    o_pass;
    logic          o_dout_valid;
    logic [AW-1:0] o_rd_addr;
    logic          o_busy;
    logic          o_done;

    int n_vec = 0;
    int n_err = 0;

    int wq[$];
    int pq[$];
    int rq[$];

    fht_seq_ctrl #(.NPT(NPT), .NPASS(NPASS), .AW(AW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_abort      (abort),
        .i_din_valid  (din_valid),
        .o_din_ready  (o_din_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_fht_star   (o_fht_star),
        .o_fb_sel     (o_fb_sel),
        .o_pass       (o_pass),
        .o_dout_valid (o_dout_valid),
        .i_dout_ready (dout_ready),
        .o_rd_addr    (o_rd_addr),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({o_din_ready, o_wr_en, o_wr_addr, o_fht_star, o_fb_sel,
                    o_pass, o_dout_valid, o_rd_addr, o_busy, o_done});
    endfunction

    // stall: toggle DinValid 1,0,1,0 during LOAD
    // bp: DoutReady low for this many cycles at RdAddr=7
    // abort_pass: >=0 aborts when that pass is executing
    // rst_at: >=0 pulses reset when LOAD reaches that write address
    // hold: keep Start high across the whole frame
    task automatic run_frame(input bit stall, input int bp, input int abort_pass,
                             input int rst_at, input bit hold);
        int cyc;
        int n_wr;
        int n_fht;
        int k;
        int bp_left;
        bit fin;
        wq.delete();
        pq.delete();
        rq.delete();
        for (int i = 0; i < NPT; i++) begin
            wq.push_back(i);
            rq.push_back(i);
        end
        for (int p = 0; p < NPASS; p++) pq.push_back((p << 1) | ((p != 0) ? 1 : 0));
        n_wr = 0;
        n_fht = 0;
        k = 0;
        bp_left = bp;
        fin = 1'b0;

        start = 1'b1;
        abort = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b1;
        #1;
        chk("idle_before_start", {o_busy, o_din_ready}, 0);
        tick();
        if (!hold) start = 1'b0;
        cyc = 1;

        while (!fin && cyc < 200) begin
            din_valid = stall ? ((k % 2) == 0) : 1'b1;
            dout_ready = 1'b1;
            if (o_dout_valid && o_rd_addr == 7 && bp_left > 0) begin
                dout_ready = 1'b0;
                bp_left--;
            end
            #1;
            if (o_din_ready) k++;
            chk("exclusive_strobes", 32'($onehot0({o_fht_star, o_wr_en, o_dout_valid})), 1);
            if (!o_din_ready) chk("wren_outside_load", o_wr_en, 0);
            if (o_wr_en) begin
                if (wq.size() > 0) chk("wr_addr", o_wr_addr, wq.pop_front());
                else chk("extra_write", 1, 0);
                n_wr++;
            end
            if (o_fht_star) begin
                chk("run_after_16_writes", n_wr, NPT);
                if (pq.size() > 0) chk("pass_fbsel", {o_pass, o_fb_sel}, pq.pop_front());
                else chk("extra_pass", 1, 0);
                n_fht++;
            end else begin
                chk("fbsel_outside_run", o_fb_sel, 0);
            end
            if (o_dout_valid && dout_ready) begin
                if (rq.size() > 0) chk("rd_addr", o_rd_addr, rq.pop_front());
                else chk("extra_read", 1, 0);
            end
            if (o_dout_valid && !dout_ready) chk("rd_addr_hold", o_rd_addr, 7);

            if (o_done) begin
                fin = 1'b1;
                chk("busy_at_done", o_busy, 0);
            end else if (abort_pass >= 0 && o_fht_star && o_pass == 2'(abort_pass)) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                #1;
                chk("abort_outputs", all_out(), 0);
                for (int j = 0; j < 4; j++) begin
                    tick();
                    chk("abort_no_done", {o_done, o_busy}, 0);
                end
                return;
            end else if (rst_at >= 0 && o_din_ready && o_wr_addr == AW'(rst_at)) begin
                #1 rst = 1'b1;
                #1 chk("rst_async_outputs", all_out(), 0);
                tick();
                chk("rst_held_outputs", all_out(), 0);
                rst = 1'b0;
                start = 1'b0;
                din_valid = 1'b0;
                #1 chk("rst_release_idle", all_out(), 0);
                return;
            end else begin
                tick();
                cyc++;
            end
        end

        if (!fin) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("done_latency", cyc, 37 + (stall ? 15 : 0) + bp);
        chk("write_count", n_wr, NPT);
        chk("fht_count", n_fht, NPASS);
        chk("queues_drained", wq.size() + pq.size() + rq.size(), 0);
        if (hold) begin
            tick();
            chk("restart_from_idle", {o_busy, o_din_ready, o_wr_addr}, {1'b1, 1'b1, 4'd0});
            start = 1'b0;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            chk("abort_cleanup", o_busy, 0);
        end else begin
            tick();
            chk("done_one_cycle", {o_done, o_busy}, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        #3;
        chk("reset_outputs", all_out(), 0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("idle_after_reset", all_out(), 0);

        // Nominal frame
        run_frame(1'b0, 0, -1, -1, 1'b0);
        // Input stall 1,0,1,0
        run_frame(1'b1, 0, -1, -1, 1'b0);
        // Output backpressure at RdAddr=7 for 5 cycles
        run_frame(1'b0, 5, -1, -1, 1'b0);
        // Abort at pass 2, then a clean frame
        run_frame(1'b0, 0, 2, -1, 1'b0);
        run_frame(1'b0, 0, -1, -1, 1'b0);

        // Abort together with Start in IDLE stays in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        #1;
        chk("abort_start_idle", {o_busy, o_din_ready}, 0);

        // Async reset mid-LOAD at WrAddr=9, then a fresh frame from address 0
        run_frame(1'b0, 0, -1, 9, 1'b0);
        run_frame(1'b0, 0, -1, -1, 1'b0);

        // Start held high across a whole frame
        run_frame(1'b0, 0, -1, -1, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
